// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch/data requester signals and the single-port memory strobes
// seen by mem_port_arbiter; master = requesters + memory model, slave = arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              halt;
    logic [DATA_W-1:0] mem_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              if_grant;
    logic              dm_grant;
    logic              if_rvalid;
    logic              dm_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              stall_if;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, halt, mem_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, if_grant, dm_grant,
               if_rvalid, dm_rvalid, rdata, stall_if
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, halt, mem_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, if_grant, dm_grant,
               if_rvalid, dm_rvalid, rdata, stall_if
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned MAX_DM_BURST = 4
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_DM = 2'd2,
        HALTED   = 2'd3
    } state_t;

    if (MAX_DM_BURST == 0 || MAX_DM_BURST > 15) begin : g_bad_burst
        $error("MAX_DM_BURST must be in 1..15");
    end

    state_t            state, state_nxt;
    logic              win_if, win_dm, starve_force;
    logic              mem_en_nxt, mem_we_nxt, stall_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;

    logic              if_grant_q, dm_grant_q, mem_en_q, mem_we_q, stall_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, rdata_q;
    logic              rd_if_q, rd_dm_q, if_rvalid_q, dm_rvalid_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] burst_cnt;

    // Fetch is forced through once data has won MAX_DM_BURST times in a row.
    assign starve_force = (burst_cnt == CNT_W'(MAX_DM_BURST)) && bus.if_req
                          && !bus.halt && (state != HALTED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= '0;
        end else if (win_if || !bus.if_req) begin
            burst_cnt <= '0;
        end else if (win_dm && (burst_cnt != {CNT_W{1'b1}})) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    // Next winner, next state and next registered memory strobes.
    always_comb begin
        state_nxt     = state;
        win_dm        = 1'b0;
        win_if        = 1'b0;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;

        if (bus.dm_req && !starve_force) begin
            win_dm = 1'b1;
        end else if (bus.if_req && !bus.halt && (state != HALTED)) begin
            win_if = 1'b1;
        end

        unique case (state)
            HALTED:  state_nxt = HALTED;
            default: begin
                if (bus.halt)    state_nxt = HALTED;
                else if (win_dm) state_nxt = GRANT_DM;
                else if (win_if) state_nxt = GRANT_IF;
                else             state_nxt = IDLE;
            end
        endcase

        if (win_dm) begin
            mem_en_nxt    = 1'b1;
            mem_we_nxt    = bus.dm_we;
            mem_addr_nxt  = bus.dm_addr;
            mem_wdata_nxt = bus.dm_wdata;
        end else if (win_if) begin
            mem_en_nxt    = 1'b1;
            mem_addr_nxt  = bus.if_addr;
        end

        stall_nxt = (state_nxt == HALTED) || (bus.if_req && !win_if);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            if_grant_q  <= 1'b0;
            dm_grant_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            if_grant_q  <= win_if;
            dm_grant_q  <= win_dm;
            mem_en_q    <= mem_en_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            stall_q     <= stall_nxt;
        end
    end

    // Read return: memory answers one cycle after the grant, owner sees it one later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_if_q     <= 1'b0;
            rd_dm_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rd_if_q     <= if_grant_q;
            rd_dm_q     <= dm_grant_q && !mem_we_q;
            if_rvalid_q <= rd_if_q;
            dm_rvalid_q <= rd_dm_q;
            if (rd_if_q || rd_dm_q) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_grant  = if_grant_q;
    assign bus.dm_grant  = dm_grant_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.stall_if  = stall_q;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 16, address width; DATA_W, 16, data width; MAX_DM_BURST, 4, consecutive data grants allowed while a fetch waits (range 1..15).
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  instruction-fetch request, level, held until if_grant.
REQ-005 if_addr  input  ADDR_W  fetch address.
REQ-006 dm_req  input  1  data-memory request, level, held until dm_grant.
REQ-007 dm_we  input  1  1 = store, 0 = load.
REQ-008 dm_addr  input  ADDR_W  data address.
REQ-009 dm_wdata  input  DATA_W  store data.
REQ-010 halt  input  1  halt opcode decoded; stops further fetch grants.
REQ-011 mem_rdata  input  DATA_W  single-port memory read data, valid one cycle after mem_en with mem_we=0.
REQ-012 mem_en, mem_we  output  1 each  registered memory strobe and write enable.
REQ-013 mem_addr / mem_wdata  output  ADDR_W / DATA_W  registered memory address and write data.
REQ-014 if_grant, dm_grant  output  1 each  one-cycle pulse: request accepted this cycle.
REQ-015 if_rvalid, dm_rvalid  output  1 each  rdata belongs to that requester this cycle.
REQ-016 rdata  output  DATA_W  registered copy of mem_rdata.
REQ-017 stall_if  output  1  high whenever if_req is high and if_grant is low, or state is HALTED.

Function
REQ-018 States SHALL be IDLE, GRANT_IF, GRANT_DM, HALTED; encoded in a 2-bit register.
REQ-019 At each edge outside HALTED, the next winner SHALL be: dm if dm_req and not starve-forced; else if if_req and not halt; else none (IDLE).
REQ-020 The winner's grant SHALL pulse in the cycle after the deciding edge, with mem_en=1 and mem_addr/mem_we/mem_wdata driven from that requester; a requester SHALL be granted at most once per request cycle (back-to-back grants allowed every cycle).
REQ-021 Fetch grants SHALL force mem_we=0 and mem_wdata=0.
REQ-022 For a read grant in cycle N, rdata SHALL equal mem_rdata sampled at the end of cycle N+1 and the owner's rvalid SHALL be high in cycle N+2 only; store grants SHALL produce no rvalid.
REQ-023 burst_cnt (4 bits) SHALL increment on each dm grant while if_req is high and clear on any if grant or when if_req is low; saturate at 15.
REQ-024 When burst_cnt == MAX_DM_BURST and if_req and not halt, the next grant SHALL go to fetch even if dm_req is high (starve-forced).
REQ-025 halt high at an edge SHALL move state to HALTED after any grant already issued completes; pending data requests SHALL still be served in HALTED, fetch never.
REQ-026 HALTED SHALL exit only on reset.
REQ-027 if_grant and dm_grant SHALL never be high in the same cycle; mem_en SHALL equal (if_grant | dm_grant).

Reset
REQ-028 reset low SHALL immediately force state=IDLE, burst_cnt=0, all grants, rvalids, mem_en, mem_we low, mem_addr, mem_wdata, rdata zero; stall_if follows REQ-017.
REQ-029 Reset mid-transaction SHALL discard any in-flight read; no rvalid SHALL appear after reset release for it.

Configuration
REQ-030 Macro MEM_ARB_STARVE_GUARD_EN: defined -> REQ-023/REQ-024 active; undefined -> burst_cnt removed and data SHALL have strict priority over fetch at all times.

Verification
REQ-031 Reset low at 2 ns, high at 8 ns -> all outputs zero during reset, state IDLE after.
REQ-032 if_req=1 with if_addr=0x0010 alone -> if_grant next cycle, mem_addr=0x0010, mem_we=0; mem_rdata=0xABCD -> rdata=0xABCD with if_rvalid two cycles after grant.
REQ-033 if_req and dm_req (load 0x0200) on the same edge -> dm_grant first, if_grant the following cycle, stall_if high for exactly one cycle.
REQ-034 dm_req held high for 10 cycles with if_req high, macro defined -> pattern of 4 dm grants, 1 if grant, repeated; macro undefined -> 10 dm grants, then if grant.
REQ-035 Store dm_we=1, dm_addr=0x0300, dm_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234, no dm_rvalid.
REQ-036 halt pulsed with if_req high -> no further if_grant, stall_if stuck high, a later dm load still granted and returned; reset clears HALTED.
